// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the NPU load/read paths.
// Both the host-side writer and the compute-side reader import this package.
package npu_mem_pkg;

    localparam int unsigned IMAGE_AW    = 10;
    localparam int unsigned RAM_AW      = 15;
    localparam int unsigned IMAGE_WORDS = 225;
    localparam int unsigned CONV_BYTES  = 18816;
    localparam int unsigned DENSE_BYTES = 16746;

    typedef enum logic [1:0] {
        IMAGE  = 2'd0,
        CONV   = 2'd1,
        DENSE  = 2'd2,
        DENSEB = 2'd3
    } src_sel_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/npu_rd_fifo.sv
// Synchronous FIFO with occupancy count, used as the reader's output buffer.
// Depth need not be a power of two; pointers wrap explicitly.
module npu_rd_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/npu_mem_reader.sv
// Compute-side reader: fetches a run of elements from one NPU RAM, hides the
// read latency with an in-flight shift register, and streams via valid/ready.
module npu_mem_reader
    import npu_mem_pkg::*;
#(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          src_sel,
    input  logic [RAM_AW-1:0]   base_addr,
    input  logic [RAM_AW-1:0]   length,
    output logic                busy,
    output logic                done,
    output logic [IMAGE_AW-1:0] image_ram_addr,
    output logic                rden_image,
    input  logic [7:0]          q0,
    input  logic [7:0]          q1,
    input  logic [7:0]          q2,
    input  logic [7:0]          q3,
    output logic [RAM_AW-1:0]   conv_ram_addr,
    output logic                rden_conv,
    input  logic [7:0]          conv_q,
    output logic [RAM_AW-1:0]   dense_ram_addr,
    output logic                rden_dense,
    input  logic [7:0]          dense_q,
    output logic [RAM_AW-1:0]   denseb_ram_addr,
    output logic                rden_denseb,
    input  logic [7:0]          denseb_q,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    rd_state_t           state, state_nxt;
    src_sel_t            src;
    logic [RAM_AW-1:0]   base, len, issued, cur_addr;
    logic [RD_LAT-1:0]   sr_valid, sr_last;
    logic                issue, pop;
    logic [31:0]         cap_data;
    logic [32:0]         fifo_head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty, fifo_full;
    int unsigned         inflight;
    logic [IMAGE_AW-1:0] image_addr_q;
    logic [RAM_AW-1:0]   conv_addr_q, dense_addr_q, denseb_addr_q;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) inflight += 32'(sr_valid[i]);
        cur_addr = base + issued;
        issue    = (state == RD_ISSUE) && (issued != len) &&
                   (32'(fifo_count) + inflight < FIFO_DEPTH);
        pop      = !fifo_empty && out_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RD_IDLE;
        else          state <= state_nxt;
    end

    // DRAIN exits on the cycle the final element is popped so done lands right after it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RD_IDLE:  if (start) state_nxt = (length == '0) ? RD_DONE : RD_ISSUE;
            RD_ISSUE: if (issued == len) state_nxt = RD_DRAIN;
            RD_DRAIN: if (inflight == 0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
                          state_nxt = RD_DONE;
            RD_DONE:  state_nxt = RD_IDLE;
            default:  state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != RD_IDLE);
        done            = (state == RD_DONE);
        rden_image      = issue && (src == IMAGE);
        rden_conv       = issue && (src == CONV);
        rden_dense      = issue && (src == DENSE);
        rden_denseb     = issue && (src == DENSEB);
        image_ram_addr  = rden_image  ? cur_addr[IMAGE_AW-1:0] : image_addr_q;
        conv_ram_addr   = rden_conv   ? cur_addr : conv_addr_q;
        dense_ram_addr  = rden_dense  ? cur_addr : dense_addr_q;
        denseb_ram_addr = rden_denseb ? cur_addr : denseb_addr_q;
        out_valid       = !fifo_empty;
        out_data        = fifo_empty ? '0 : fifo_head[31:0];
        out_last        = !fifo_empty && fifo_head[32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src           <= IMAGE;
            base          <= '0;
            len           <= '0;
            issued        <= '0;
            sr_valid      <= '0;
            sr_last       <= '0;
            image_addr_q  <= '0;
            conv_addr_q   <= '0;
            dense_addr_q  <= '0;
            denseb_addr_q <= '0;
        end else begin
            if (state == RD_IDLE && start) begin
                src    <= src_sel_t'(src_sel);
                base   <= base_addr;
                len    <= length;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + RAM_AW'(1);
            end
            sr_valid[0] <= issue;
            sr_last[0]  <= issue && (issued == len - RAM_AW'(1));
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_last[i]  <= sr_last[i-1];
            end
            if (rden_image)  image_addr_q  <= cur_addr[IMAGE_AW-1:0];
            if (rden_conv)   conv_addr_q   <= cur_addr;
            if (rden_dense)  dense_addr_q  <= cur_addr;
            if (rden_denseb) denseb_addr_q <= cur_addr;
        end
    end

    always_comb begin
        cap_data = '0;
        unique case (src)
            IMAGE:   cap_data = {q0, q1, q2, q3};
            CONV:    cap_data = {24'h0, conv_q};
            DENSE:   cap_data = {24'h0, dense_q};
            DENSEB:  cap_data = {24'h0, denseb_q};
            default: cap_data = '0;
        endcase
    end

    npu_rd_fifo #(
        .WIDTH(33),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (sr_valid[RD_LAT-1]),
        .wdata  ({sr_last[RD_LAT-1], cap_data}),
        .pop    (pop),
        .rdata  (fifo_head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

endmodule

// File: doc/npu_mem_reader.md
# npu_mem_reader

Read-side companion to the NPU load path. Once the host writer has filled the image banks and the conv, dense and dense-bias weight RAMs, the compute engine uses this block to fetch from them. A single `start` command selects a source RAM, a base address and an element count. The block issues reads while hiding the RAM read latency and streams the results out on a valid/ready interface with a last flag.

## Interface
Parameters:
- `RD_LAT`, 2: RAM read latency in cycles, from `rden` to `q` valid.
- `FIFO_DEPTH`, 4: output buffer entries. Must be ≥ `RD_LAT`+2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe. Sampled only in IDLE.
- `src_sel` in 2: source select. 0 = image, 1 = conv, 2 = dense, 3 = denseb.
- `base_addr` in 15: first address.
- `length` in 15: element count. 0 means no-op.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `image_ram_addr` out 10, `rden_image` out 1: shared address and read enable for the four image banks.
- `q0`, `q1`, `q2`, `q3` in 8: image bank read data.
- `conv_ram_addr` out 15, `rden_conv` out 1, `conv_q` in 8.
- `dense_ram_addr` out 15, `rden_dense` out 1, `dense_q` in 8.
- `denseb_ram_addr` out 15, `rden_denseb` out 1, `denseb_q` in 8.
- `out_data` out 32, `out_valid` out 1, `out_ready` in 1, `out_last` out 1.

## Operation
- States and transitions:
  - IDLE → ISSUE on `start`. `src_sel`, `base_addr` and `length` are latched. If `length`==0, go IDLE → DONE instead.
  - ISSUE → DRAIN when issued count == `length`.
  - DRAIN → DONE when no reads are in flight and the FIFO is empty.
  - DONE → IDLE unconditionally.
- Issue rule:
  - One read per cycle in ISSUE while `fifo_count + inflight < FIFO_DEPTH`.
  - On issue, exactly one `rden_*` (the selected one) is high, with address = base + issued.
  - All other `rden_*` are 0, and all `rden_*` are 0 outside issue cycles.
  - Non-selected address outputs hold their value.
- Address arithmetic:
  - Modulo the port width: 15 bits, 10 bits for image (low 10 bits of the sum). Wrap is silent.
  - No range check against RAM sizes.
- In-flight tracking:
  - An `RD_LAT`-deep valid shift register, with a last tag on the final issue.
  - When a slot exits, the selected `q` is captured into the FIFO.
- Data formatting:
  - Image: {q0, q1, q2, q3}, with q0 in [31:24].
  - Conv, dense, denseb: {24'b0, byte}.
- Output:
  - FIFO head drives `out_data` and `out_last`; `out_valid` = FIFO not empty.
  - A pop happens on `out_valid && out_ready`.
  - `out_data` holds stable while valid and not ready.
- Busy/done:
  - `busy` is high from the cycle after `start` accept through the DONE cycle inclusive.
  - `done` is high only in DONE.
- `start` while busy is ignored; the latched command is unchanged.
- Simultaneous FIFO push and pop in the same cycle leaves the count unchanged.
- Reset, including mid-operation:
  - State returns to IDLE; counters, shift register and FIFO are cleared; in-flight data is discarded.
  - All outputs go to 0: addresses, `rden_*`, `busy`, `done`, `out_valid`, `out_data`, `out_last`.
  - The next `start` after reset release behaves normally.

## Timing
- Cycle numbering: `start` is sampled at the edge ending cycle 0.
  - Cycle 1: first `rden`, address = `base_addr`.
  - Cycle 1+`RD_LAT`: `q` valid; pushed into the FIFO at the end of that cycle.
  - Cycle 2+`RD_LAT` (cycle 4 by default): first `out_valid`.
- Throughput:
  - With `out_ready` held high: one element per cycle, no bubbles.
  - Length N: last handshake at cycle N+`RD_LAT`+1; `done` at the following cycle.
- Backpressure: issuing stalls within one cycle of the credit limit. No element is ever dropped or duplicated.
- Length 0: `done` in cycle 1, `busy` high only in cycle 1, no `rden`, no `out_valid`.

## Structure
- Package `npu_mem_pkg`:
  - `src_sel_t` enum (IMAGE, CONV, DENSE, DENSEB) and the reader state enum.
  - Constants IMAGE_WORDS=225, CONV_BYTES=18816, DENSE_BYTES=16746.
  - Address widths 10 and 15.
  - Shared with the load-side writer.
- Sub-module `npu_rd_fifo`: synchronous FIFO, width 33 (data + last), depth `FIFO_DEPTH`, with a count output. Async active-low reset.

## Test plan
- Reset: hold `reset_n`=0 mid-stream → all outputs 0 immediately; after release, `busy`=0 and `out_valid`=0.
- Image read, bank k word a preloaded to (k<<4)|a, `base_addr`=0, `length`=3, ready high:
  - `out_data` = 0x00102030, 0x01112131, 0x02122232 in cycles 4, 5, 6.
  - `out_last` on the third element; `done` in cycle 7.
- Conv read, `base_addr`=18813, `length`=3, `out_ready` toggling 1,0,1,0 → bytes at 18813..18815 delivered in order, `out_data` stable while stalled, `fifo_count + inflight` never exceeds 4.
- `length`=0 → `done` pulse in cycle 1, no `rden_*`, no `out_valid`.
- Denseb read, `base_addr`=32767, `length`=2 → addresses 32767 then 0; only `rden_denseb` toggles.
- `start` pulsed during a dense transfer of length 5 → ignored; exactly 5 outputs with the original base; a single `done`.
